alu_arbiter: RTL
================

# alu_arbiter

Shares the single combinational ALU (`alu`) between two requesters, such as the execute stage and a debug/multiply microsequencer. Each requester issues one operation under a valid/ready handshake and receives a registered result and NZCV flags under a second handshake. The arbiter grants round-robin, keeps one operation in flight, and owns the architectural flag register, which is updated only by flag-setting operations.

## Interface
Parameters:
- `NREQ`, 2: number of requesters. Fixed at 2; the round-robin pointer is 1 bit.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `req_valid`  in  [NREQ-1:0]  request pending, per requester
- `req_ready`  out  [NREQ-1:0]  request accepted this cycle, per requester
- `req_a`, `req_b`  in  [NREQ-1:0][31:0]  operands
- `req_op`  in  [NREQ-1:0][1:0]  opcode: 00 ADD, 01 SUB, 10 AND, 11 ORR
- `req_setflags`  in  [NREQ-1:0]  when 1, the result's flags update `flags_q`
- `rsp_valid`  out  [NREQ-1:0]  result available, one-hot to the owning requester
- `rsp_ready`  in  [NREQ-1:0]  requester takes the result
- `rsp_data`  out  32  registered ALU result
- `rsp_flags`  out  4  registered flags of this operation: [0] N, [1] Z, [2] C, [3] V
- `flags_q`  out  4  architectural NZCV register, same bit order

## Operation
- States are IDLE, EXEC and RESP.
- IDLE:
  - Grant goes to the pointer's requester if its `req_valid` is 1, otherwise to the other requester if its `req_valid` is 1.
  - `req_ready[g]` is 1 combinationally for the granted requester only.
  - On the handshake, latch a, b, op, setflags and owner index g. Set the pointer to ~g. Go to EXEC.
  - With no valid request, stay in IDLE and leave the pointer unchanged.
- EXEC:
  - Drive the latched operands into `alu`.
  - Register its `c` into `rsp_data` and its `flags` into `rsp_flags`.
  - If setflags is 1, load `flags_q` with the ALU flags in the same edge.
  - Go to RESP.
- RESP:
  - Assert `rsp_valid[owner]`.
  - Hold `rsp_data` and `rsp_flags` stable until `rsp_ready[owner]` is 1, then go to IDLE.
  - `rsp_ready` of the non-owner is ignored.
- `req_ready` is 0 in EXEC and RESP, so no new request is accepted until the response is consumed. Back-to-back throughput is one operation per 3 cycles.
- Arithmetic follows `alu`:
  - 32-bit wraparound.
  - C is the carry-out of a+b, or of a+~b+1 for SUB.
  - C and V are cleared for AND and ORR.
  - Z is set iff the result is 0; N equals result bit 31.

## Timing
- Reset, while `reset_n` is 0 at an edge:
  - State goes to IDLE and the pointer to 0.
  - `rsp_valid`, `rsp_data`, `rsp_flags` and `flags_q` go to 0.
  - `req_ready` is 0 while `reset_n` is 0.
  - Reset in EXEC or RESP aborts the operation: no response, and `flags_q` is cleared.
- Latency: handshake at edge t; result registered at edge t+1; `rsp_valid` high from the cycle after edge t+1. A response with `rsp_ready` already 1 frees IDLE at edge t+2.
- `flags_q` changes exactly at edge t+1, before `rsp_valid` rises. A setflags=0 operation never changes it.
- Simultaneous `req_valid` on both requesters: the pointer decides. Alternation is strict under continuous contention.
- A requester may drop `req_valid` before the handshake; it has no effect.
- `req_*` inputs are sampled only on the handshake edge.

## Structure
- Shared package `alu_pkg` holds:
  - opcode constants `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_ORR`
  - flag index constants `FLAG_N=0`, `FLAG_Z=1`, `FLAG_C=2`, `FLAG_V=3`
  - the state enum `arb_state_t` {IDLE, EXEC, RESP}
- One sub-module: the existing `alu`, instantiated once and fed from the operand latches.
- Arbitration and the state machine stay inline; no further hierarchy.

## Test plan
- Reset, then requester 0 sends ADD 0x7FFFFFFF + 1 with setflags=1:
  - `rsp_valid` = 01, `rsp_data` = 0x80000000, `rsp_flags` = 1001 (V, N).
  - `flags_q` = 1001 at edge t+1.
- Requester 1 sends SUB 5 - 5 with setflags=0 → `rsp_data` = 0, `rsp_flags` = 0110 (C, Z), `flags_q` unchanged.
- Both requesters valid continuously with AND/ORR ops → grants alternate 0,1,0,1; each operation takes exactly 3 cycles when `rsp_ready` is held at 1.
- Hold `rsp_ready` = 0 for 5 cycles in RESP:
  - `rsp_data` and `rsp_flags` stay stable.
  - `req_ready` stays 00 while the other requester is valid.
  - Release → IDLE, then the other requester is granted.
- Assert `reset_n` = 0 during EXEC of ADD 0xFFFFFFFF + 1 → no `rsp_valid`; `flags_q` = 0 and the pointer is 0 after release.
- The non-owner asserts `rsp_ready` during RESP → ignored; the response remains pending.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, flag-index and state definitions for the ALU arbiter
//
// Purpose : constants and types shared by alu, alu_arbiter_if and alu_arbiter.
// Contents: ALU_* opcodes, FLAG_* bit positions within an NZCV nibble,
//           arb_state_t arbiter state encoding.
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam int FLAG_N = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response bundle between requesters and the ALU arbiter
//
// Purpose : groups the per-requester request and response handshakes.
// Signals : req_valid/req_ready/req_a/req_b/req_op/req_setflags (request side),
//           rsp_valid/rsp_ready/rsp_data/rsp_flags (response side).
// Modports: master = requesters, slave = arbiter.
interface alu_arbiter_if #(
  parameter int NREQ = 2
) ();

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][31:0] req_a;
  logic [NREQ-1:0][31:0] req_b;
  logic [NREQ-1:0][1:0]  req_op;
  logic [NREQ-1:0]       req_setflags;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [31:0]           rsp_data;
  logic [3:0]            rsp_flags;

  modport master (
    output req_valid, req_a, req_b, req_op, req_setflags, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_flags
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_setflags, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_flags
  );

endinterface

// File: rtl/alu.sv
// rtl/alu.sv - combinational 32-bit ALU with NZCV flags
//
// Purpose : ADD/SUB/AND/ORR on two 32-bit operands.
// Ports   : a_i, b_i  operands
//           op_i      opcode (ALU_ADD/SUB/AND/ORR)
//           c_o       result
//           flags_o   NZCV, bit positions FLAG_N/Z/C/V
module alu
  import alu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [1:0]  op_i,
  output logic [31:0] c_o,
  output logic [3:0]  flags_o
);

  logic        is_sub;
  logic [31:0] b_eff;
  logic [32:0] sum;
  logic        carry;
  logic        ovf;

  // SUB is a + ~b + 1 so the carry-out is the ARM-style "no borrow" flag.
  assign is_sub = (op_i == ALU_SUB);
  assign b_eff  = is_sub ? ~b_i : b_i;
  assign sum    = {1'b0, a_i} + {1'b0, b_eff} + {32'b0, is_sub};

  always_comb begin
    c_o   = 32'b0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op_i)
      ALU_ADD, ALU_SUB: begin
        c_o   = sum[31:0];
        carry = sum[32];
        // Overflow: like-signed inputs to the adder producing an opposite-signed sum.
        ovf   = (a_i[31] == b_eff[31]) && (sum[31] != a_i[31]);
      end
      ALU_AND: c_o = a_i & b_i;
      default: c_o = a_i | b_i;
    endcase
  end

  always_comb begin
    flags_o         = 4'b0;
    flags_o[FLAG_N] = c_o[31];
    flags_o[FLAG_Z] = (c_o == 32'b0);
    flags_o[FLAG_C] = carry;
    flags_o[FLAG_V] = ovf;
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU between two requesters
//
// Purpose : grants one operation at a time, registers the result and its
//           flags, and owns the architectural NZCV register.
// Ports   : clk      rising-edge clock
//           reset_n  synchronous active-low reset
//           bus      alu_arbiter_if slave (request/response handshakes)
//           flags_q  architectural NZCV register
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  alu_arbiter_if.slave bus,
  output logic [3:0]   flags_q
);

  arb_state_t  state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        owner_q, owner_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic        setf_q, setf_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  rflags_q, rflags_d;
  logic [3:0]  flags_d;

  logic            gnt_any;
  logic            gnt_idx;
  logic [31:0]     alu_c;
  logic [3:0]      alu_flags;
  logic [NREQ-1:0] ready_oh;
  logic [NREQ-1:0] valid_oh;

  alu u_alu (
    .a_i     (a_q),
    .b_i     (b_q),
    .op_i    (op_q),
    .c_o     (alu_c),
    .flags_o (alu_flags)
  );

  // The pointer's requester wins; otherwise fall through to the other one.
  assign gnt_any = |bus.req_valid;
  assign gnt_idx = bus.req_valid[ptr_q] ? ptr_q : ~ptr_q;

  assign ready_oh = NREQ'(1) << gnt_idx;
  assign valid_oh = NREQ'(1) << owner_q;

  assign bus.req_ready = (reset_n && (state_q == IDLE) && gnt_any) ? ready_oh : '0;
  assign bus.rsp_valid = (state_q == RESP) ? valid_oh : '0;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_flags = rflags_q;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    setf_d   = setf_q;
    data_d   = data_q;
    rflags_d = rflags_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          a_d     = bus.req_a[gnt_idx];
          b_d     = bus.req_b[gnt_idx];
          op_d    = bus.req_op[gnt_idx];
          setf_d  = bus.req_setflags[gnt_idx];
          owner_d = gnt_idx;
          ptr_d   = ~gnt_idx;
          state_d = EXEC;
        end
      end
      EXEC: begin
        data_d   = alu_c;
        rflags_d = alu_flags;
        if (setf_q) flags_d = alu_flags;
        state_d  = RESP;
      end
      RESP: begin
        if (bus.rsp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      owner_q  <= 1'b0;
      a_q      <= 32'b0;
      b_q      <= 32'b0;
      op_q     <= ALU_ADD;
      setf_q   <= 1'b0;
      data_q   <= 32'b0;
      rflags_q <= 4'b0;
      flags_q  <= 4'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      setf_q   <= setf_d;
      data_q   <= data_d;
      rflags_q <= rflags_d;
      flags_q  <= flags_d;
    end
  end

endmodule
